// File: rtl/alu_share_arbiter.sv
// Round-robin owner of one shared 8-bit ALU for two req/done requesters.
// Captures the winner's opcode/operands, waits one cycle for the ALU, then returns its result.
module alu_share_arbiter #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [OPW-1:0] op0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  output logic           gnt0,
  output logic           done0,
  output logic [W-1:0]   z0,
  input  logic           req1,
  input  logic [OPW-1:0] op1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt1,
  output logic           done1,
  output logic [W-1:0]   z1,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_z,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   any_req;
  logic   win;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) begin
      win = ~last_grant;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      z0         <= '0;
      z1         <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state)
        // capture: winner's operands drive the ALU from here on
        IDLE: begin
          if (any_req) begin
            owner      <= win;
            last_grant <= win;
            alu_op     <= win ? op1 : op0;
            alu_a      <= win ? a1  : a0;
            alu_b      <= win ? b1  : b0;
            gnt0       <= ~win;
            gnt1       <= win;
            state      <= EXEC;
          end
        end
        // execute: ALU output has settled, latch it for the owner only
        EXEC: begin
          if (owner) begin
            z1 <= alu_z;
          end else begin
            z0 <= alu_z;
          end
          done0 <= ~owner;
          done1 <= owner;
          state <= RESP;
        end
        // respond: release grant and done together
        RESP: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a
// timestamp-based schedule model of grants, dones and results.
module tb_alu_share_arbiter;
  localparam int W   = 8;
  localparam int OPW = 3;

  logic           clk  = 1'b0;
  logic           rst  = 1'b1;
  logic           req0 = 1'b0;
  logic           req1 = 1'b0;
  logic [OPW-1:0] op0  = '0;
  logic [OPW-1:0] op1  = '0;
  logic [W-1:0]   a0   = '0;
  logic [W-1:0]   b0   = '0;
  logic [W-1:0]   a1   = '0;
  logic [W-1:0]   b1   = '0;
  logic           gnt0, gnt1, done0, done1, busy;
  logic [W-1:0]   z0, z1, alu_a, alu_b, alu_z;
  logic [OPW-1:0] alu_op;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0), .z0(z0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1), .z1(z1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z), .busy(busy)
  );

  function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return ~(a & b);
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  assign alu_z = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Schedule model: an operation accepted at edge cap owns the ALU for edges cap..cap+1,
  // finishes at cap+1, and the next acceptance may happen no earlier than cap+3.
  int             k, cap, next_arb;
  logic           act, mw, last;
  logic [OPW-1:0] mop;
  logic [W-1:0]   ma, mb, mval;
  logic [W-1:0]   mz [2];
  logic           m_any, m_win;

  always_comb begin
    m_any = req0 | req1;
    if (req0 && !req1)      m_win = 1'b0;
    else if (req1 && !req0) m_win = 1'b1;
    else if (last == 1'b0)  m_win = 1'b1;
    else                    m_win = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0; cap <= 0; next_arb <= 0; act <= 1'b0; mw <= 1'b0; last <= 1'b1;
      mop <= '0; ma <= '0; mb <= '0; mval <= '0; mz[0] <= '0; mz[1] <= '0;
    end else begin
      k <= k + 1;
      if (act && (k + 1 == cap + 2)) act <= 1'b0;
      if (act && (k + 1 == cap + 1)) mz[mw] <= mval;
      if ((k + 1 >= next_arb) && m_any) begin
        act      <= 1'b1;
        cap      <= k + 1;
        next_arb <= k + 4;
        mw       <= m_win;
        last     <= m_win;
        mop      <= m_win ? op1 : op0;
        ma       <= m_win ? a1 : a0;
        mb       <= m_win ? b1 : b0;
        mval     <= m_win ? alu_fn(op1, a1, b1) : alu_fn(op0, a0, b0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt0",  32'(gnt0),  32'(act && mw == 1'b0));
      chk("gnt1",  32'(gnt1),  32'(act && mw == 1'b1));
      chk("done0", 32'(done0), 32'(act && mw == 1'b0 && k == cap + 1));
      chk("done1", 32'(done1), 32'(act && mw == 1'b1 && k == cap + 1));
      chk("busy",  32'(busy),  32'(act));
      chk("z0",    32'(z0),    32'(mz[0]));
      chk("z1",    32'(z1),    32'(mz[1]));
      chk("alu_op", 32'(alu_op), 32'(mop));
      chk("alu_a", 32'(alu_a), 32'(ma));
      chk("alu_b", 32'(alu_b), 32'(mb));
      chk("gnt_excl",  32'(gnt0 & gnt1),   32'(0));
      chk("done_excl", 32'(done0 & done1), 32'(0));
    end
  end

  task automatic run_pair(output int d0, output int d1);
    d0 = -1;
    d1 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0) begin d0 = cyc; req0 = 1'b0; end
      if (done1) begin d1 = cyc; req1 = 1'b0; end
    end
  endtask

  initial begin
    int d0, d1;
    int order[$];
    int dl[$];
    logic pg0, pg1;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'(0));
    chk("rst_gnt1", 32'(gnt1), 32'(0));
    chk("rst_done", 32'({done0, done1}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_z", 32'({z0, z1}), 32'(0));
    chk("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
    rst = 1'b0;

    // single request
    req0 = 1'b1; op0 = 3'b000; a0 = 8'b00010010; b0 = 8'b01000101;
    @(negedge clk);
    chk("single_gnt_c1", 32'({gnt0, done0, busy}), 32'(3'b101));
    @(negedge clk);
    chk("single_gnt_c2", 32'({gnt0, done0, busy}), 32'(3'b111));
    req0 = 1'b0;
    @(negedge clk);
    chk("single_idle", 32'({gnt0, done0, busy}), 32'(3'b000));
    chk("single_z0", 32'(z0), 32'(8'b11111111));
    chk("single_z1", 32'(z1), 32'(0));

    // tie after reset
    @(negedge clk);
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; op0 = 3'b000; a0 = 8'h12; b0 = 8'h45;
    req1 = 1'b1; op1 = 3'b000; a1 = 8'b00010110; b1 = 8'b01010101;
    @(negedge clk);
    chk("tie_first", 32'({gnt0, gnt1}), 32'(2'b10));
    run_pair(d0, d1);
    chk("tie_done0_seen", 32'(d0 >= 0), 32'(1));
    chk("tie_spacing", 32'(d1 - d0), 32'(3));
    chk("tie_z1", 32'(z1), 32'(8'b11101011));

    // continuous contention
    req0 = 1'b1; op0 = 3'd4; a0 = 8'h10; b0 = 8'h22;
    req1 = 1'b1; op1 = 3'd5; a1 = 8'h40; b1 = 8'h01;
    pg0 = 1'b0; pg1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0 && !pg0) order.push_back(0);
      if (gnt1 && !pg1) order.push_back(1);
      if (done0 || done1) dl.push_back(cyc);
      pg0 = gnt0; pg1 = gnt1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_ngrants", 32'(order.size()), 32'(4));
    for (int i = 0; i < order.size() && i < 4; i++) chk("cont_order", 32'(order[i]), 32'(i % 2));
    for (int i = 1; i < dl.size(); i++) chk("cont_done_gap", 32'(dl[i] - dl[i-1]), 32'(3));
    chk("cont_z0", 32'(z0), 32'(8'h32));
    chk("cont_z1", 32'(z1), 32'(8'h3F));
    repeat (2) @(negedge clk);

    // operand change after capture
    req0 = 1'b1; op0 = 3'b000; a0 = 8'h0F; b0 = 8'h3C;
    @(negedge clk);
    a0 = 8'hFF;
    @(negedge clk);
    chk("opchg_done", 32'(done0), 32'(1));
    chk("opchg_z0", 32'(z0), 32'(8'hF3));
    req0 = 1'b0;
    @(negedge clk);

    // late request during port 0 EXEC
    req0 = 1'b1; op0 = 3'd1; a0 = 8'h5A; b0 = 8'h0F;
    @(negedge clk);
    req1 = 1'b1; op1 = 3'd3; a1 = 8'h5A; b1 = 8'hFF;
    run_pair(d0, d1);
    chk("late_spacing", 32'(d1 - d0), 32'(3));
    chk("late_z0", 32'(z0), 32'(8'h0A));
    chk("late_z1", 32'(z1), 32'(8'hA5));

    // asynchronous reset in the middle of EXEC
    req0 = 1'b1; op0 = 3'd0; a0 = 8'h00; b0 = 8'h00;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstx_gnt", 32'({gnt0, gnt1, busy}), 32'(0));
    chk("rstx_done", 32'({done0, done1}), 32'(0));
    chk("rstx_z", 32'({z0, z1}), 32'(0));
    chk("rstx_alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
    req0 = 1'b0;
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rstx_no_done", 32'({done0, done1, busy}), 32'(0));
    req0 = 1'b1; op0 = 3'd2; a0 = 8'h81; b0 = 8'h18;
    req1 = 1'b1; op1 = 3'd6; a1 = 8'h0F; b1 = 8'h00;
    @(negedge clk);
    chk("rstx_tie", 32'({gnt0, gnt1}), 32'(2'b10));
    run_pair(d0, d1);
    chk("rstx_tie_spacing", 32'(d1 - d0), 32'(3));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 300) begin
        #3 rst = 1'b1;
        #1;
        chk("rand_rst", 32'({gnt0, gnt1, done0, done1, busy}), 32'(0));
        #2 rst = 1'b0;
      end
      if (done0) begin
        if ($urandom_range(3) != 0) req0 = 1'b0;
      end else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
      end else if (gnt0 && $urandom_range(1) == 0) begin
        op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
      end
      if (done1) begin
        if ($urandom_range(3) != 0) req1 = 1'b0;
      end else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      end else if (gnt1 && $urandom_range(1) == 0) begin
        op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
